// File: rtl/caravel_la_pkg.sv
// Purpose: shared checkpoint codes, pad bit-field and FSM state type for the LA test sequencer.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package caravel_la_pkg;

    // Progress codes posted on the user I/O checkpoint field
    localparam logic [15:0] CP_START  = 16'hAB40;
    localparam logic [15:0] CP_PHASE1 = 16'hAB41;
    localparam logic [15:0] CP_PASS   = 16'hAB51;
    localparam logic [15:0] CP_FAIL   = 16'hAB50;

    // Pad bits that carry the checkpoint code
    localparam int CP_HI = 31;
    localparam int CP_LO = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_BOOT   = 3'd1,
        ST_PHASE1 = 3'd2,
        ST_PHASE2 = 3'd3,
        ST_FINISH = 3'd4
    } state_t;

endpackage

// File: rtl/caravel_la_loopback.sv
// Purpose: stand-in user project for the LA bus: echoes the core-driven half, counts on the other half.
// Latency: echo half lags the core-driven half by one cycle; counter half advances every cycle.
// Backpressure: none; free-running from reset.
module caravel_la_loopback #(
    parameter int LA_WIDTH = 64
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [LA_WIDTH/2-1:0] core_lo,
    output logic [LA_WIDTH-1:0]   la_model
);

    localparam int HALF = LA_WIDTH / 2;

    logic [HALF-1:0] echo_q;
    logic [HALF-1:0] ctr_q;

    // One-cycle echo of the core's lower half plus a counter that never stops
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            echo_q <= '0;
            ctr_q  <= '0;
        end else begin
            echo_q <= core_lo;
            ctr_q  <= ctr_q + HALF'(1);
        end
    end

    assign la_model = {echo_q, ctr_q};

endmodule

// File: rtl/caravel_la_test_core.sv
// Purpose: LA bus test sequencer posting checkpoint codes on mprj_io[31:16]; CARAVEL_LA_LOOPBACK_EN swaps la_data_in for an internal model.
// Latency: first code BOOT_CYCLES+1 clocks after leaving debug mode, then RUN_CYCLES per LA phase.
// Backpressure: none; the user side must keep pace every cycle or the run records a failure.
module caravel_la_test_core
    import caravel_la_pkg::*;
#(
    parameter int BOOT_CYCLES = 16,
    parameter int RUN_CYCLES  = 256,
    parameter int LA_WIDTH    = 64,
    parameter int IO_WIDTH    = 38
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [IO_WIDTH-1:0] mprj_io_in,
    output logic [IO_WIDTH-1:0] mprj_io_out,
    output logic [IO_WIDTH-1:0] mprj_io_oeb,
    output logic [LA_WIDTH-1:0] la_data_out,
    output logic [LA_WIDTH-1:0] la_oenb,
    input  logic [LA_WIDTH-1:0] la_data_in,
    output logic                done,
    output logic                pass
);

    localparam int HALF    = LA_WIDTH / 2;
    localparam int CNT_MAX = (RUN_CYCLES > BOOT_CYCLES) ? RUN_CYCLES : BOOT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] BOOT_LAST = CNT_W'(BOOT_CYCLES - 1);
    localparam logic [CNT_W-1:0] RUN_LAST  = CNT_W'(RUN_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic [15:0]      cp_q, cp_d;
    logic             cp_oe_q, cp_oe_d;
    logic [HALF-1:0]  prev_q, prev_d;
    logic [LA_WIDTH-1:0] la_in;

    // Only the debug-request bit of the pad inputs matters here
    logic unused_io;
    assign unused_io = ^mprj_io_in[IO_WIDTH-1:1];

`ifdef CARAVEL_LA_LOOPBACK_EN
    logic unused_la_in;
    assign unused_la_in = ^la_data_in;

    caravel_la_loopback #(
        .LA_WIDTH (LA_WIDTH)
    ) u_loopback (
        .clock    (clock),
        .reset    (reset),
        .core_lo  (la_data_out[HALF-1:0]),
        .la_model (la_in)
    );
`else
    assign la_in = la_data_in;
`endif

    // State, counters, sticky error and the registered checkpoint code
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            cp_q    <= '0;
            cp_oe_q <= 1'b0;
            prev_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            cp_q    <= cp_d;
            cp_oe_q <= cp_oe_d;
            prev_q  <= prev_d;
        end
    end

    // Sequencing and LA checks; the code register is only loaded on transitions so it never glitches
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        cp_d    = cp_q;
        cp_oe_d = cp_oe_q;
        prev_d  = prev_q;
        case (state_q)
            ST_IDLE: begin
                if (!mprj_io_in[0]) begin
                    state_d = ST_BOOT;
                    cnt_d   = '0;
                end
            end
            ST_BOOT: begin
                if (cnt_q == BOOT_LAST) begin
                    state_d = ST_PHASE1;
                    cnt_d   = '0;
                    cp_d    = CP_START;
                    cp_oe_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_PHASE1: begin
                // Echo of cycle k-1 is due on the upper half in cycle k
                if (cnt_q != '0 && la_in[LA_WIDTH-1:HALF] != (HALF'(cnt_q) - HALF'(1)))
                    err_d = 1'b1;
                if (cnt_q == RUN_LAST) begin
                    state_d = ST_PHASE2;
                    cnt_d   = '0;
                    cp_d    = CP_PHASE1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_PHASE2: begin
                // Modulo-2^HALF increment, so the all-ones to zero step is legal
                prev_d = la_in[HALF-1:0];
                if (cnt_q != '0 && la_in[HALF-1:0] != (prev_q + HALF'(1)))
                    err_d = 1'b1;
                if (cnt_q == RUN_LAST) begin
                    state_d = ST_FINISH;
                    cnt_d   = '0;
                    cp_d    = err_d ? CP_FAIL : CP_PASS;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_FINISH: begin
                state_d = ST_FINISH;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Pads: only the checkpoint field is ever driven; everything else stays an input
    always_comb begin
        mprj_io_out = '0;
        mprj_io_oeb = '1;
        mprj_io_out[CP_HI:CP_LO] = cp_q;
        mprj_io_oeb[CP_HI:CP_LO] = {16{~cp_oe_q}};
    end

    // LA bus: the core drives the lower half only while echo-testing
    always_comb begin
        la_oenb     = '1;
        la_data_out = '0;
        if (state_q == ST_PHASE1) begin
            la_oenb[HALF-1:0]     = '0;
            la_data_out[HALF-1:0] = HALF'(cnt_q);
        end
    end

    assign done = (state_q == ST_FINISH);
    assign pass = done & ~err_q;

endmodule

// File: tb/tb_caravel_la_test_core.sv
module tb_caravel_la_test_core;

    localparam int BOOT = 16;
    localparam int RUN  = 256;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [37:0] mprj_io_in = '0;
    logic [37:0] mprj_io_out, mprj_io_oeb;
    logic [63:0] la_data_out, la_oenb, la_data_in;
    logic        done, pass;

    int n_pass  = 0;
    int n_total = 0;

    // User-project model: echo register, loadable counter, fault knobs
    logic [31:0] echo_q = '0;
    logic [31:0] ctr_q = '0;
    logic [31:0] ctr_base = '0;
    logic        ctr_load = 1'b0;
    logic        skip_en = 1'b0;
    logic        corrupt_en = 1'b0;

    always #5 clock = ~clock;

    always @(posedge clock) begin
        echo_q <= la_data_out[31:0];
        if (ctr_load)                 ctr_q <= ctr_base;
        else if (skip_en && ctr_q == 32'd5) ctr_q <= 32'd7;
        else                          ctr_q <= ctr_q + 32'd1;
    end

    assign la_data_in = {(corrupt_en && !la_oenb[0] && la_data_out[31:0] == 32'd100) ? 32'd0 : echo_q,
                         ctr_q};

    caravel_la_test_core #(
        .BOOT_CYCLES (BOOT),
        .RUN_CYCLES  (RUN),
        .LA_WIDTH    (64),
        .IO_WIDTH    (38)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .mprj_io_in  (mprj_io_in),
        .mprj_io_out (mprj_io_out),
        .mprj_io_oeb (mprj_io_oeb),
        .la_data_out (la_data_out),
        .la_oenb     (la_oenb),
        .la_data_in  (la_data_in),
        .done        (done),
        .pass        (pass)
    );

    task automatic do_reset(input logic dbg);
        @(negedge clock);
        reset = 1'b1;
        mprj_io_in = {37'd0, dbg};
        repeat (3) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clock);
        reset = 1'b1;
        #1;
        n_total++; if (mprj_io_out !== 38'd0) $display("FAIL rst_io_out got %h want 0", mprj_io_out); else n_pass++;
        n_total++; if (mprj_io_oeb !== {38{1'b1}}) $display("FAIL rst_io_oeb got %h want all ones", mprj_io_oeb); else n_pass++;
        n_total++; if (la_data_out !== 64'd0) $display("FAIL rst_la_out got %h want 0", la_data_out); else n_pass++;
        n_total++; if (la_oenb !== {64{1'b1}}) $display("FAIL rst_la_oenb got %h want all ones", la_oenb); else n_pass++;
        n_total++; if (done !== 1'b0) $display("FAIL rst_done got %b want 0", done); else n_pass++;
        n_total++; if (pass !== 1'b0) $display("FAIL rst_pass got %b want 0", pass); else n_pass++;
    endtask

    task automatic test_debug_hold();
        logic bad;
        bad = 1'b0;
        do_reset(1'b1);
        repeat (100) begin
            @(negedge clock);
            if (mprj_io_oeb !== {38{1'b1}} || mprj_io_out !== 38'd0 || done !== 1'b0) bad = 1'b1;
        end
        n_total++; if (bad) $display("FAIL dbg_hold got activity want idle pads"); else n_pass++;
        mprj_io_in[0] = 1'b0;
        repeat (BOOT) @(negedge clock);
        n_total++; if (mprj_io_oeb[31:16] !== 16'hFFFF || mprj_io_out[31:16] !== 16'h0)
            $display("FAIL dbg_early got oeb %h code %h want ffff 0000", mprj_io_oeb[31:16], mprj_io_out[31:16]); else n_pass++;
        @(negedge clock);
        n_total++; if (mprj_io_out !== {6'h0, 16'hAB40, 16'h0})
            $display("FAIL dbg_start_code got %h want ab40 in [31:16]", mprj_io_out); else n_pass++;
        n_total++; if (mprj_io_oeb !== {6'h3F, 16'h0, 16'hFFFF})
            $display("FAIL dbg_start_oeb got %h want 3f0000ffff", mprj_io_oeb); else n_pass++;
        n_total++; if (la_oenb !== {32'hFFFF_FFFF, 32'h0})
            $display("FAIL p1_oenb got %h want ffffffff00000000", la_oenb); else n_pass++;
        repeat (5) @(negedge clock);
        n_total++; if (la_data_out !== 64'd5) $display("FAIL p1_k5 got %h want 5", la_data_out); else n_pass++;
    endtask

    task automatic run_check(input string name, input logic [31:0] base, input logic corrupt,
                             input logic skip, input logic [15:0] exp_code, input logic exp_pass);
        logic [15:0] seq [3];
        logic [15:0] code, prev;
        int cyc, idx, t40, t41;
        logic bad_seq;
        seq[0] = 16'hAB40; seq[1] = 16'hAB41; seq[2] = exp_code;
        prev = 16'h0; idx = 0; t40 = -1; t41 = -1; bad_seq = 1'b0; cyc = 0;
        corrupt_en = corrupt;
        skip_en = skip;
        do_reset(1'b0);
        while (cyc < 1200 && done !== 1'b1) begin
            @(negedge clock);
            ctr_load = 1'b0;
            code = mprj_io_out[31:16];
            if (code !== prev) begin
                if (idx > 2 || code !== seq[idx]) bad_seq = 1'b1;
                if (code === 16'hAB40) begin
                    t40 = cyc;
                    ctr_base = base;
                    ctr_load = 1'b1;
                end
                if (code === 16'hAB41) t41 = cyc;
                idx++;
                prev = code;
            end
            cyc++;
        end
        n_total++; if (done !== 1'b1) $display("FAIL %s_timeout done %b want 1", name, done); else n_pass++;
        n_total++; if (bad_seq || idx != 3) $display("FAIL %s_sequence got %0d changes last %h want ab40,ab41,%h", name, idx, prev, exp_code); else n_pass++;
        n_total++; if (t41 - t40 != RUN) $display("FAIL %s_phase1_len got %0d want %0d", name, t41 - t40, RUN); else n_pass++;
        n_total++; if (mprj_io_out[31:16] !== exp_code) $display("FAIL %s_code got %h want %h", name, mprj_io_out[31:16], exp_code); else n_pass++;
        n_total++; if (pass !== exp_pass) $display("FAIL %s_pass got %b want %b", name, pass, exp_pass); else n_pass++;
        corrupt_en = 1'b0;
        skip_en = 1'b0;
    endtask

    task automatic test_reset_mid_phase1();
        int cyc;
        do_reset(1'b0);
        cyc = 0;
        while (cyc < 100 && mprj_io_out[31:16] !== 16'hAB40) begin
            @(negedge clock);
            cyc++;
        end
        n_total++; if (mprj_io_out[31:16] !== 16'hAB40) $display("FAIL mid_reach_p1 got %h want ab40", mprj_io_out[31:16]); else n_pass++;
        repeat (50) @(negedge clock);
        reset = 1'b1;
        #1;
        n_total++; if (mprj_io_out !== 38'd0 || mprj_io_oeb !== {38{1'b1}})
            $display("FAIL mid_rst_pads got out %h oeb %h want 0 / all ones", mprj_io_out, mprj_io_oeb); else n_pass++;
        n_total++; if (la_data_out !== 64'd0 || la_oenb !== {64{1'b1}})
            $display("FAIL mid_rst_la got out %h oenb %h want 0 / all ones", la_data_out, la_oenb); else n_pass++;
        @(negedge clock);
        reset = 1'b0;
        repeat (BOOT + 1) @(negedge clock);
        n_total++; if (mprj_io_out[31:16] !== 16'hAB40) $display("FAIL mid_restart got %h want ab40", mprj_io_out[31:16]); else n_pass++;
        cyc = 0;
        while (cyc < 1000 && done !== 1'b1) begin
            @(negedge clock);
            cyc++;
        end
        n_total++; if (done !== 1'b1 || mprj_io_out[31:16] !== 16'hAB51)
            $display("FAIL mid_finish got done %b code %h want 1 ab51", done, mprj_io_out[31:16]); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_debug_hold();
        run_check("nominal", 32'h0000_1000, 1'b0, 1'b0, 16'hAB51, 1'b1);
        run_check("echo_bad", 32'h0000_1000, 1'b1, 1'b0, 16'hAB50, 1'b0);
        run_check("ctr_skip", 32'hFFFF_FEA2, 1'b0, 1'b1, 16'hAB50, 1'b0);
        run_check("ctr_wrap", 32'hFFFF_FE9C, 1'b0, 1'b0, 16'hAB51, 1'b1);
        test_reset_mid_phase1();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/caravel_la_test_core.md
Name: caravel_la_test_core

Overview:
- Self-checking logic-analyzer (LA) test sequencer for the caravel management side.
- Reports progress as 16-bit checkpoint codes on user I/O bits [31:16].
- Exercises the LA bus to the user project in two phases: core-driven echo check, then user-driven counter check.
- The final checkpoint code gives pass/fail status.

Parameters:
- BOOT_CYCLES, 16: idle cycles between leaving IDLE and posting the first checkpoint.
- RUN_CYCLES, 256: cycles spent in each LA phase.
- LA_WIDTH, 64: LA bus width; must be even, halves are LA_WIDTH/2.
- IO_WIDTH, 38: user I/O width; must be at least 32.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- mprj_io_in  in  IO_WIDTH  pad input values; bit 0 = debug-mode request.
- mprj_io_out  out  IO_WIDTH  pad output values.
- mprj_io_oeb  out  IO_WIDTH  pad output enable, active-low (1 = input).
- la_data_out  out  LA_WIDTH  core-to-user LA data.
- la_oenb  out  LA_WIDTH  LA direction per bit (0 = core drives).
- la_data_in  in  LA_WIDTH  user-to-core LA data.
- done  out  1  high once the final checkpoint is posted.
- pass  out  1  valid while done=1; 1 = no mismatch.

Behaviour:
- Reset (asynchronous, immediate, also mid-operation):
  - mprj_io_out=0, mprj_io_oeb=all 1, la_data_out=0, la_oenb=all 1.
  - done=0, pass=0, error flag=0, counters=0, state=IDLE.
- States: IDLE, BOOT, PHASE1, PHASE2, FINISH.
- IDLE: stay while mprj_io_in[0]=1 (debug mode); otherwise go to BOOT on the next clock.
- BOOT: count BOOT_CYCLES cycles. On exit:
  - mprj_io_oeb[31:16]=0, mprj_io_out[31:16]=16'hAB40.
  - Enter PHASE1. The code is visible on the first PHASE1 cycle.
- PHASE1 (RUN_CYCLES cycles, cycle index k = 0..RUN_CYCLES-1):
  - la_oenb[LA_WIDTH/2-1:0]=0; upper half stays 1.
  - la_data_out[LA_WIDTH/2-1:0]=k (zero-extended); upper half stays 0.
  - The user project echoes the lower half with one-cycle latency on la_data_in[LA_WIDTH-1:LA_WIDTH/2].
  - For k>=1, compare la_data_in upper half with k-1. Any mismatch sets the sticky error flag.
  - On exit: mprj_io_out[31:16]=16'hAB41, la_oenb=all 1, la_data_out=0. Enter PHASE2.
- PHASE2 (RUN_CYCLES cycles):
  - The core only listens. Sample la_data_in[LA_WIDTH/2-1:0] every cycle.
  - From the second cycle on, require sample = previous sample + 1, modulo 2^(LA_WIDTH/2).
  - Mismatch sets the error flag.
- FINISH:
  - mprj_io_out[31:16]=16'hAB51 if the error flag is clear, else 16'hAB50.
  - done=1, pass=~error. Hold until reset.
- Fixed pads: mprj_io_out/oeb bits outside [31:16] are never driven (oeb=1, out=0). Bit 3 (CSB) and bit 0 are inputs only.
- Counter wrap: the phase counter wraps naturally at RUN_CYCLES. The wrap in the PHASE2 comparison is a legal increment.
- Checkpoint codes change only on state transitions, each in a single cycle, and never glitch through other values.

Optional Feature:
- Macro CARAVEL_LA_LOOPBACK_EN. When defined, la_data_in is ignored and replaced by an internal model:
  - Upper half = registered lower half of la_data_out (one-cycle echo).
  - Lower half = free-running counter incremented every cycle from reset.
- Result: a stand-alone run always finishes with 16'hAB51.
- When undefined, la_data_in is used directly and no model logic is present.

Decomposition:
- Package caravel_la_pkg:
  - Checkpoint constants CP_START=16'hAB40, CP_PHASE1=16'hAB41, CP_PASS=16'hAB51, CP_FAIL=16'hAB50.
  - State enum.
  - Checkpoint bit-field constants (hi=31, lo=16).
- Sub-module caravel_la_loopback: the loopback model, instantiated only under CARAVEL_LA_LOOPBACK_EN.

Test Plan:
- Hold mprj_io_in[0]=1 for 100 cycles after reset -> mprj_io_oeb all 1, mprj_io_out=0, done=0; release -> [31:16]=16'hAB40 after BOOT_CYCLES+1 cycles.
- Correct one-cycle echo on upper LA half plus incrementing counter on lower half -> sequence AB40, AB41 (after 256 cycles), AB51; done=1, pass=1.
- Corrupt echo at PHASE1 k=100 (upper half = 0) -> final code 16'hAB50, pass=0.
- PHASE2 counter skips one value (5→7) -> 16'hAB50.
- Counter wraps 32'hFFFFFFFF→0 in PHASE2 -> no error, 16'hAB51.
- Assert reset during PHASE1 -> all outputs return to reset values immediately; after release the sequence restarts at 16'hAB40.
